sync_down_counter: RTL and testbench

//   Synchronous binary down counter built from cascaded 4-bit slices; the count-down

---
 rtl/sync_down_counter_pkg.sv | 21 ++
 rtl/sync_down_counter_slice4.sv | 40 ++++
 rtl/sync_down_counter.sv | 79 +++++++
 tb/tb_sync_down_counter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_down_counter_pkg.sv
// Purpose: shared constants and helpers for the sliced down counter.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   SLICE_W        width of one counter slice
//   cnt_width()    total counter width for a given slice count
//   slice_lsb()    bit offset of slice k inside the full count
package sync_down_counter_pkg;

  localparam int SLICE_W = 4;

  function automatic int cnt_width(input int nslice);
    return SLICE_W * nslice;
  endfunction

  function automatic int slice_lsb(input int k);
    return SLICE_W * k;
  endfunction

endpackage

// File: rtl/sync_down_counter_slice4.sv
// Purpose: one 4-bit synchronous down-counting slice with load and borrow-out.
// Latency: Q updates one CLK edge after a qualifying input; RCO is combinational.
// Backpressure: none; ENP/ENT are plain enables, ENT doubles as the cascade input.
//
// Ports:
//   CLK   rising-edge clock
//   CLR   synchronous clear, active high (highest priority)
//   LD_L  synchronous parallel load, active low
//   D     load value
//   ENP   count enable (does not affect RCO)
//   ENT   count enable / cascade input (gates RCO)
//   Q     slice count
//   RCO   borrow-out: Q==0 && ENT
module down_slice4
  import sync_down_counter_pkg::*;
(
  input  logic               CLK,
  input  logic               CLR,
  input  logic               LD_L,
  input  logic [SLICE_W-1:0] D,
  input  logic               ENP,
  input  logic               ENT,
  output logic [SLICE_W-1:0] Q,
  output logic               RCO
);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      Q <= '0;
    end else if (!LD_L) begin
      Q <= D;
    end else if (ENP && ENT) begin
      // 0 wraps to all ones; the borrow is seen by the next slice through RCO
      Q <= Q - SLICE_W'(1);
    end
  end

  assign RCO = (Q == '0) && ENT;

endmodule

// File: rtl/sync_down_counter.sv
// Purpose: W-bit synchronous down counter from cascaded 4-bit slices, optional auto-reload.
// Latency: Q/TC_P update one CLK edge after a qualifying input; RCO is combinational from Q/ENT.
// Backpressure: none; ENP/ENT gate counting, ENT also gates RCO for cascading.
//
// Ports:
//   CLK   rising-edge clock
//   CLR   synchronous clear, active high; beats load, reload and count
//   LD_L  synchronous parallel load, active low
//   D     parallel load value, also the auto-reload value
//   ENP   count enable P
//   ENT   count enable T, gates RCO
//   Q     current count
//   RCO   borrow-out: Q==0 && ENT
//   TC_P  registered pulse: the previous counting step brought Q from 1 to 0
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int NSLICE  = 2,
  parameter bit AUTO_RL = 1'b0
)
(
  input  logic                        CLK,
  input  logic                        CLR,
  input  logic                        LD_L,
  input  logic [SLICE_W*NSLICE-1:0]   D,
  input  logic                        ENP,
  input  logic                        ENT,
  output logic [SLICE_W*NSLICE-1:0]   Q,
  output logic                        RCO,
  output logic                        TC_P
);

  localparam int W = cnt_width(NSLICE);

  logic          pt;
  logic          q_zero;
  logic          q_one;
  logic          reload;
  logic          slice_ld_l;
  logic [NSLICE:0] ent_chain;

  assign pt     = ENP && ENT;
  assign q_zero = (Q == '0);
  assign q_one  = (Q == W'(1));

  // Auto-reload is a load request shared by every slice: at terminal count the
  // whole word takes D instead of letting the slices wrap to all ones.
  assign reload     = AUTO_RL && q_zero && pt;
  assign slice_ld_l = LD_L && !reload;

  // Slice k counts only when ENT and every lower slice is zero; each slice's
  // RCO feeds the next slice's ENT, so the chain end equals (Q==0) && ENT.
  assign ent_chain[0] = ENT;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    down_slice4 u_slice (
      .CLK  (CLK),
      .CLR  (CLR),
      .LD_L (slice_ld_l),
      .D    (D[slice_lsb(k) +: SLICE_W]),
      .ENP  (ENP),
      .ENT  (ent_chain[k]),
      .Q    (Q[slice_lsb(k) +: SLICE_W]),
      .RCO  (ent_chain[k+1])
    );
  end

  assign RCO = ent_chain[NSLICE];

  // Only a genuine 1 -> 0 counting step raises TC_P; loading zero does not.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      TC_P <= 1'b0;
    end else begin
      TC_P <= LD_L && pt && q_one;
    end
  end

endmodule

// File: tb/tb_sync_down_counter.sv
// Purpose: self-checking bench for sync_down_counter, wrap and auto-reload variants side by side.
// Latency: model updates on each rising CLK edge; outputs sampled 1 time unit later.
// Backpressure: n/a.
module tb_sync_down_counter;

  localparam int NSLICE = 2;
  localparam int W      = 4 * NSLICE;
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  logic         clk;
  logic         clr;
  logic         ld_l;
  logic [W-1:0] d;
  logic         enp;
  logic         ent;

  logic [W-1:0] q_a;
  logic         rco_a;
  logic         tc_a;
  logic [W-1:0] q_b;
  logic         rco_b;
  logic         tc_b;

  // reference state: a = wrapping counter, b = auto-reload counter
  logic [W-1:0] m_q_a;
  logic [W-1:0] m_q_b;
  logic         m_tc_a;
  logic         m_tc_b;

  int checks;
  int errors;

  sync_down_counter #(.NSLICE(NSLICE), .AUTO_RL(1'b0)) u_dut_a (
    .CLK(clk), .CLR(clr), .LD_L(ld_l), .D(d), .ENP(enp), .ENT(ent),
    .Q(q_a), .RCO(rco_a), .TC_P(tc_a)
  );

  sync_down_counter #(.NSLICE(NSLICE), .AUTO_RL(1'b1)) u_dut_b (
    .CLK(clk), .CLR(clr), .LD_L(ld_l), .D(d), .ENP(enp), .ENT(ent),
    .Q(q_b), .RCO(rco_b), .TC_P(tc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next count from the behavioural rules: clear, load, count, hold.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] q, input bit auto_rl);
    if (clr)             return '0;
    if (!ld_l)           return d;
    if (!(enp && ent))   return q;
    if (q != 0)          return q - 1;
    if (auto_rl)         return d;
    return ALL_ONES;
  endfunction

  function automatic logic model_tc(input logic [W-1:0] q);
    return !clr && ld_l && enp && ent && (q == 1);
  endfunction

  // Advance one edge: compute the model from the pre-edge inputs, then sample.
  task automatic tick();
    logic [W-1:0] na, nb;
    logic         ta, tb;
    na = model_next(m_q_a, 1'b0);
    nb = model_next(m_q_b, 1'b1);
    ta = model_tc(m_q_a);
    tb = model_tc(m_q_b);
    @(posedge clk);
    #1;
    m_q_a  = na;
    m_q_b  = nb;
    m_tc_a = ta;
    m_tc_b = tb;
  endtask

  task automatic drive(input logic c, input logic l, input logic [W-1:0] dv,
                       input logic p, input logic t);
    clr = c; ld_l = l; d = dv; enp = p; ent = t;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    tick();
    checks++;
    if (q_a !== 8'h00 || q_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_q: got a=%h b=%h want 00", q_a, q_b);
    end
    checks++;
    if (tc_a !== 1'b0 || tc_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_tc: got a=%b b=%b want 0", tc_a, tc_b);
    end
    checks++;
    if (rco_a !== 1'b1 || rco_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_rco_ent1: got a=%b b=%b want 1", rco_a, rco_b);
    end
    ent = 1'b0;
    #1;
    checks++;
    if (rco_a !== 1'b0 || rco_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_rco_ent0: got a=%b b=%b want 0", rco_a, rco_b);
    end
  endtask

  task automatic test_load_count();
    logic [W-1:0] exp_a [4];
    logic [W-1:0] exp_b [4];
    exp_a = '{8'h02, 8'h01, 8'h00, 8'hFF};
    exp_b = '{8'h02, 8'h01, 8'h00, 8'h03};
    drive(1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    tick();
    checks++;
    if (q_a !== 8'h03 || tc_a !== 1'b0) begin
      errors++;
      $display("FAIL load_03: got q=%h tc=%b want 03/0", q_a, tc_a);
    end
    drive(1'b0, 1'b1, 8'h03, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q_a !== exp_a[i] || q_b !== exp_b[i]) begin
        errors++;
        $display("FAIL count_step%0d: got a=%h b=%h want %h %h", i, q_a, q_b, exp_a[i], exp_b[i]);
      end
      checks++;
      if (tc_a !== (i == 2) || tc_b !== (i == 2)) begin
        errors++;
        $display("FAIL count_tc%0d: got a=%b b=%b want %b", i, tc_a, tc_b, (i == 2));
      end
      checks++;
      if (rco_a !== (i == 2)) begin
        errors++;
        $display("FAIL count_rco%0d: got %b want %b", i, rco_a, (i == 2));
      end
    end
  endtask

  task automatic test_borrow();
    drive(1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    tick();
    checks++;
    if (q_a !== 8'h0F || q_b !== 8'h0F) begin
      errors++;
      $display("FAIL borrow_10: got a=%h b=%h want 0F", q_a, q_b);
    end
  endtask

  task automatic test_auto_reload();
    int pulses;
    pulses = 0;
    drive(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h04, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (tc_b === 1'b1) pulses++;
      checks++;
      if (q_b !== m_q_b || q_a !== m_q_a) begin
        errors++;
        $display("FAIL reload_q%0d: got a=%h b=%h want %h %h", i, q_a, q_b, m_q_a, m_q_b);
      end
      checks++;
      if (tc_b !== ((i % 5) == 4)) begin
        errors++;
        $display("FAIL reload_tc%0d: got %b want %b", i, tc_b, ((i % 5) == 4));
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL reload_pulses: got %0d want 3", pulses);
    end
  endtask

  task automatic test_enables();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    checks++;
    if (q_a !== 8'h00 || rco_a !== 1'b0 || q_b !== 8'h00 || rco_b !== 1'b0) begin
      errors++;
      $display("FAIL ent0_hold: got q=%h rco=%b want 00/0", q_a, rco_a);
    end
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    tick();
    checks++;
    if (q_a !== 8'h00 || rco_a !== 1'b1 || q_b !== 8'h00 || rco_b !== 1'b1) begin
      errors++;
      $display("FAIL enp0_hold: got q=%h rco=%b want 00/1", q_a, rco_a);
    end
    // RCO must not react to LD_L or CLR between edges
    ld_l = 1'b0; clr = 1'b1;
    #1;
    checks++;
    if (rco_a !== 1'b1) begin
      errors++;
      $display("FAIL rco_indep: got %b want 1", rco_a);
    end
    clr = 1'b0; ld_l = 1'b1;
  endtask

  task automatic test_clr_mid();
    drive(1'b0, 1'b0, 8'h05, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h05, 1'b1, 1'b1);
    tick();
    tick();
    drive(1'b1, 1'b0, 8'h05, 1'b1, 1'b1);
    tick();
    checks++;
    if (q_a !== 8'h00 || q_b !== 8'h00 || tc_a !== 1'b0) begin
      errors++;
      $display("FAIL clr_mid: got a=%h b=%h tc=%b want 00/0", q_a, q_b, tc_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
            (($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
      #1;
      checks++;
      if (rco_a !== ((m_q_a == 0) && ent) || rco_b !== ((m_q_b == 0) && ent)) begin
        errors++;
        $display("FAIL rand_rco%0d: got a=%b b=%b", i, rco_a, rco_b);
      end
      tick();
      checks++;
      if (q_a !== m_q_a || q_b !== m_q_b) begin
        errors++;
        $display("FAIL rand_q%0d: got a=%h b=%h want %h %h", i, q_a, q_b, m_q_a, m_q_b);
      end
      checks++;
      if (tc_a !== m_tc_a || tc_b !== m_tc_b) begin
        errors++;
        $display("FAIL rand_tc%0d: got a=%b b=%b want %b %b", i, tc_a, tc_b, m_tc_a, m_tc_b);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_q_a = '0; m_q_b = '0; m_tc_a = 1'b0; m_tc_b = 1'b0;
    drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_load_count();
    test_borrow();
    test_auto_reload();
    test_enables();
    test_clr_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
